alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_serial_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU controller.
// Holds the op encoding driven onto m1:m0 and the controller state encoding.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: feeds operands LSB first to an external
// combinational 1-bit slice and assembles the result word and status flags.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready, op,      request handshake, operation and operands
//   op_a, op_b
//   a_bit, b_bit, cin_bit,      drives to the 1-bit slice (0 outside SHIFT)
//   m0, m1
//   f_bit, cout_bit, n_bit      slice returns, same cycle
//   out_valid/out_ready,        result handshake, result word and flags
//   result, flag_z/c/n
//   flag_v                      signed overflow, only with ALU_SERIAL_OVF_EN
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             a_bit,
    output logic             b_bit,
    output logic             cin_bit,
    output logic             m0,
    output logic             m1,
    input  logic             f_bit,
    input  logic             cout_bit,
    input  logic             n_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
`ifdef ALU_SERIAL_OVF_EN
    output logic             flag_v,
`endif
    output logic             flag_n
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             eq_q, gt_q, lt_q;

    logic             accept;
    logic             in_shift;
    logic             last;
    logic             is_arith;
    logic [WIDTH-1:0] res_nxt;
    logic             eq_nxt, gt_nxt, lt_nxt;

    assign accept   = (state_q == IDLE) && in_valid;
    assign in_shift = (state_q == SHIFT);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign res_nxt  = {f_bit, result[WIDTH-1:1]};

    // A differing bit overrides the compare state; later bits are more significant.
    assign eq_nxt = f_bit ? eq_q : 1'b0;
    assign gt_nxt = f_bit ? gt_q : cout_bit;
    assign lt_nxt = f_bit ? lt_q : n_bit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and slice/handshake decode
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        cin_bit   = 1'b0;
        m0        = 1'b0;
        m1        = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                a_bit   = a_sh[0];
                b_bit   = b_sh[0];
                cin_bit = is_arith ? carry_q : 1'b0;
                m0      = op_q[0];
                m1      = op_q[1];
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand shifting, result assembly and flag capture on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            a_sh    <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            flag_v  <= 1'b0;
`endif
        end else if (accept) begin
            op_q    <= op;
            a_sh    <= op_a;
            b_sh    <= op_b;
            cnt     <= '0;
            carry_q <= (op == OP_SUB);
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            result  <= '0;
        end else if (in_shift) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CW'(1);
            if (op_q != OP_CMP) result <= res_nxt;
            if (is_arith)       carry_q <= cout_bit;
            if (op_q == OP_CMP) begin
                eq_q <= eq_nxt;
                gt_q <= gt_nxt;
                lt_q <= lt_nxt;
            end
            if (last) begin
                case (op_q)
                    OP_CMP: begin
                        flag_z <= eq_nxt;
                        flag_c <= gt_nxt;
                        flag_n <= lt_nxt;
                    end
                    OP_AND: begin
                        flag_z <= (res_nxt == '0);
                        flag_c <= 1'b0;
                        flag_n <= f_bit;
                    end
                    default: begin
                        flag_z <= (res_nxt == '0);
                        flag_c <= cout_bit;
                        flag_n <= f_bit;
                    end
                endcase
`ifdef ALU_SERIAL_OVF_EN
                // Carry into the MSB is the carry register during the last bit.
                flag_v <= is_arith ? (carry_q ^ cout_bit) : 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=4). Models the 1-bit slice
// behaviourally and checks results against whole-word arithmetic.
// Covers flag_v when ALU_SERIAL_OVF_EN is defined.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] op_a, op_b;
    logic         a_bit, b_bit, cin_bit, m0, m1;
    logic         f_bit, cout_bit, n_bit;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z, flag_c, flag_n;
`ifdef ALU_SERIAL_OVF_EN
    logic         flag_v;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .cin_bit   (cin_bit),
        .m0        (m0),
        .m1        (m1),
        .f_bit     (f_bit),
        .cout_bit  (cout_bit),
        .n_bit     (n_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
`ifdef ALU_SERIAL_OVF_EN
        .flag_v    (flag_v),
`endif
        .flag_n    (flag_n)
    );

    // Behavioural 1-bit slice
    always_comb begin
        f_bit    = 1'b0;
        cout_bit = 1'b0;
        n_bit    = 1'b0;
        case ({m1, m0})
            2'b00: begin
                f_bit    = a_bit ^ b_bit ^ cin_bit;
                cout_bit = (a_bit & b_bit) | (a_bit & cin_bit) | (b_bit & cin_bit);
            end
            2'b01: begin
                f_bit    = a_bit ^ ~b_bit ^ cin_bit;
                cout_bit = (a_bit & ~b_bit) | (a_bit & cin_bit) | (~b_bit & cin_bit);
            end
            2'b10: begin
                f_bit    = ~(a_bit ^ b_bit);
                cout_bit = a_bit & ~b_bit;
                n_bit    = ~a_bit & b_bit;
            end
            default: f_bit = a_bit & b_bit;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Word-level reference: unsigned arithmetic and sign bits.
    task automatic model(input int o, input int a, input int b,
                         output int res, output int z, output int c,
                         output int n, output int v);
        int mask, sa, sb, sr;
        mask = (1 << W) - 1;
        sa = (a >> (W - 1)) & 1;
        sb = (b >> (W - 1)) & 1;
        v = 0;
        c = 0;
        case (o)
            0: begin
                res = (a + b) & mask;
                c   = ((a + b) > mask) ? 1 : 0;
                sr  = (res >> (W - 1)) & 1;
                v   = (sa == sb && sr != sa) ? 1 : 0;
            end
            1: begin
                res = (a - b) & mask;
                c   = (a >= b) ? 1 : 0;
                sr  = (res >> (W - 1)) & 1;
                v   = (sa != sb && sr != sa) ? 1 : 0;
            end
            2: res = 0;
            default: res = a & b;
        endcase
        if (o == 2) begin
            z = (a == b) ? 1 : 0;
            c = (a > b) ? 1 : 0;
            n = (a < b) ? 1 : 0;
        end else begin
            z = (res == 0) ? 1 : 0;
            n = (res >> (W - 1)) & 1;
        end
    endtask

    task automatic run_op(input int o, input int a, input int b, input int stall);
        int res, ez, ec, en, ev, edges;
        model(o, a, b, res, ez, ec, en, ev);
        @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'(1));
        op       = 2'(o);
        op_a     = W'(a);
        op_b     = W'(b);
        in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        check_eq("mode_bits", 32'({m1, m0}), 32'(o));
        check_eq("in_ready_busy", 32'(in_ready), 32'(0));
        // Scrambled request while busy must be ignored
        op   = 2'($urandom);
        op_a = W'($urandom);
        op_b = W'($urandom);
        while (!out_valid && edges < 3 * W + 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("latency", 32'(edges), 32'(W + 1));
        check_eq("result", 32'(result), 32'(res));
        check_eq("flag_z", 32'(flag_z), 32'(ez));
        check_eq("flag_c", 32'(flag_c), 32'(ec));
        check_eq("flag_n", 32'(flag_n), 32'(en));
`ifdef ALU_SERIAL_OVF_EN
        check_eq("flag_v", 32'(flag_v), 32'(ev));
`endif
        check_eq("slice_idle", 32'({a_bit, b_bit, cin_bit, m0, m1}), 32'(0));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'(1));
            check_eq("hold_result", 32'(result), 32'(res));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("drain_valid", 32'(out_valid), 32'(0));
        check_eq("drain_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic reset_mid_shift();
        int seen;
        @(negedge clk);
        op       = 2'(0);
        op_a     = W'(3);
        op_b     = W'(4);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_result", 32'(result), 32'(0));
        check_eq("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * W + 2; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_eq("no_valid_after_rst", 32'(seen), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_valid", 32'(out_valid), 32'(0));
        check_eq("reset_result", 32'(result), 32'(0));
        check_eq("reset_flags", 32'({flag_z, flag_c, flag_n}), 32'(0));
        check_eq("reset_slice", 32'({a_bit, b_bit, cin_bit, m0, m1}), 32'(0));
        rst_n = 1'b1;

        run_op(0, 7, 9, 0);
        run_op(1, 3, 5, 1);
        run_op(1, 5, 3, 0);
        run_op(2, 5, 5, 0);
        run_op(2, 10, 5, 0);
        run_op(2, 3, 8, 0);
        run_op(3, 12, 10, 3);
        run_op(0, 7, 1, 0);
        run_op(0, 2, 3, 0);
        run_op(1, 0, 0, 0);
        run_op(0, 15, 15, 2);

        reset_mid_shift();
        run_op(0, 1, 1, 0);

        for (int k = 0; k < 40; k++) begin
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
